// File: rtl/ram_req_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and helpers for the RAM request controller.
//   state_e : controller state (INIT = zero-fill, RUN = serving requests)
//   rsp_t   : one response FIFO entry {err, data}
//   in_range: address range check against the populated RAM size
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_BITS = 12;
  localparam int unsigned DEF_DATA_BITS = 16;
  localparam int unsigned DEF_RAM_SIZE  = 3072;
  localparam int unsigned RSP_DEPTH     = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Sized by DEF_DATA_BITS; instances must keep DATA_BITS at this value.
  typedef struct packed {
    logic                     err;
    logic [DEF_DATA_BITS-1:0] data;
  } rsp_t;

  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] size);
    return addr < size;
  endfunction

endpackage

// File: rtl/ram_req_ctrl_if.sv
// ram_req_ctrl_if: request/response stream plus the RAM strobe bus.
//   slave  : controller side (accepts requests, drives responses and RAM strobes)
//   master : client side (issues requests, consumes responses, models the RAM)
interface ram_req_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
);
  logic                 REQ_VALID;
  logic                 REQ_READY;
  logic                 REQ_WRITE;
  logic [ADDR_BITS-1:0] REQ_ADDR;
  logic [DATA_BITS-1:0] REQ_DATA;
  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [DATA_BITS-1:0] RSP_DATA;
  logic                 RSP_ERR;
  logic                 INIT_DONE;
  logic                 RAM_RST_N;
  logic                 RAM_RDEN;
  logic                 RAM_WREN;
  logic [ADDR_BITS-1:0] RAM_ADDR;
  logic [DATA_BITS-1:0] RAM_WDATA;
  logic [DATA_BITS-1:0] RAM_RDATA;

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_DATA, RSP_READY, RAM_RDATA,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, INIT_DONE,
           RAM_RST_N, RAM_RDEN, RAM_WREN, RAM_ADDR, RAM_WDATA
  );

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_DATA, RSP_READY, RAM_RDATA,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, INIT_DONE,
           RAM_RST_N, RAM_RDEN, RAM_WREN, RAM_ADDR, RAM_WDATA
  );
endinterface

// File: rtl/ram_req_ctrl_rsp_fifo.sv
// rsp_fifo: small in-order FIFO holding read responses.
//   CLK/RST        : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : enqueue one entry
//   pop            : dequeue the head (ignored when empty)
//   head           : current head entry (valid when count != 0)
//   count          : number of stored entries
module rsp_fifo #(
  parameter  int unsigned DEPTH = 3,
  parameter  int unsigned WIDTH = 17,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is only honoured when the head leaves the same cycle.
  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) rd_d = ptr_inc(rd_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: front-end for a single-port synchronous RAM with 1-cycle read latency.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : request stream in, response stream out, RAM strobes out / RAM read data in
// After reset every word is zero-filled (INIT), then requests are served (RUN).
// Out-of-range writes are dropped; out-of-range reads answer {err=1, data=0}.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned RAM_SIZE  = DEF_RAM_SIZE
) (
  input  logic           CLK,
  input  logic           RST,
  ram_req_ctrl_if.slave  bus
);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] fill_q, fill_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_err_q, inflight_err_d;
  logic [CW-1:0]        fifo_cnt;
  rsp_t                 push_rsp, head_rsp;
  logic                 accept, addr_ok, rsp_pop;

  assign addr_ok = in_range(32'(bus.REQ_ADDR), RAM_SIZE);

  // Credit check counts the read still waiting on RAM_RDATA, so a full FIFO
  // can never be overrun; uses registered state only.
  assign bus.REQ_READY = (state_q == RUN) &&
                         ((SW'(fifo_cnt) + SW'(inflight_q)) < SW'(RSP_DEPTH));
  assign accept        = bus.REQ_VALID && bus.REQ_READY;
  assign bus.INIT_DONE = (state_q == RUN);
  assign bus.RAM_RST_N = !RST;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= INIT;
      fill_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      inflight_q     <= inflight_d;
      inflight_err_q <= inflight_err_d;
    end
  end

  // Next state: walk the fill counter over every populated word, then run.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (state_q == INIT) begin
      fill_d = fill_q + ADDR_BITS'(1);
      if (fill_q == ADDR_BITS'(RAM_SIZE - 1)) begin
        state_d = RUN;
        fill_d  = '0;
      end
    end
  end

  // Outputs: RAM strobes and the in-flight read marker.
  always_comb begin
    bus.RAM_RDEN   = 1'b0;
    bus.RAM_WREN   = 1'b0;
    bus.RAM_ADDR   = '0;
    bus.RAM_WDATA  = '0;
    inflight_d     = 1'b0;
    inflight_err_d = 1'b0;
    if (state_q == INIT) begin
      bus.RAM_WREN = 1'b1;
      bus.RAM_ADDR = fill_q;
    end else if (accept) begin
      if (bus.REQ_WRITE) begin
        if (addr_ok) begin
          bus.RAM_WREN  = 1'b1;
          bus.RAM_ADDR  = bus.REQ_ADDR;
          bus.RAM_WDATA = bus.REQ_DATA;
        end
      end else begin
        inflight_d     = 1'b1;
        inflight_err_d = !addr_ok;
        if (addr_ok) begin
          bus.RAM_RDEN = 1'b1;
          bus.RAM_ADDR = bus.REQ_ADDR;
        end
      end
    end
  end

  // RAM_RDATA is valid the cycle after the read strobe; capture it then.
  always_comb begin
    push_rsp.err  = inflight_err_q;
    push_rsp.data = inflight_err_q ? '0 : bus.RAM_RDATA;
  end

  assign rsp_pop = bus.RSP_VALID && bus.RSP_READY;

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_rsp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (inflight_q),
    .push_data (push_rsp),
    .pop       (rsp_pop),
    .head      (head_rsp),
    .count     (fifo_cnt)
  );

  // Gate the head so stale storage never shows on an idle response port.
  assign bus.RSP_VALID = (fifo_cnt != '0);
  assign bus.RSP_DATA  = bus.RSP_VALID ? head_rsp.data : '0;
  assign bus.RSP_ERR   = bus.RSP_VALID && head_rsp.err;
endmodule
